// File: rtl/cmd_wb_pkg.sv
// Shared command definitions for the byte-stream to Wishbone bridge:
// word-size encodings, FSM state type and lane-mapping helpers.
package cmd_wb_pkg;

   localparam logic [1:0] CMD_WSIZE_1BYTE = 2'd1;
   localparam logic [1:0] CMD_WSIZE_2BYTE = 2'd2;
   localparam logic [1:0] CMD_WSIZE_4BYTE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_WB_REQ,
      ST_WB_ACK,
      ST_TX
   } state_t;

   // Bytes per word; the reserved encoding behaves as a single byte.
   function automatic logic [2:0] wsize_bytes(input logic [1:0] wsize);
      case (wsize)
         CMD_WSIZE_4BYTE: return 3'd4;
         CMD_WSIZE_2BYTE: return 3'd2;
         default:         return 3'd1;
      endcase
   endfunction

   // Lowest byte lane carrying data for this word size and address.
   function automatic logic [1:0] first_lane(input logic [1:0] wsize, input logic [1:0] lo);
      case (wsize)
         CMD_WSIZE_4BYTE: return 2'd0;
         CMD_WSIZE_2BYTE: return {lo[1], 1'b0};
         default:         return lo;
      endcase
   endfunction

   // Wishbone byte-select pattern for this word size and address.
   function automatic logic [3:0] lane_sel(input logic [1:0] wsize, input logic [1:0] lo);
      case (wsize)
         CMD_WSIZE_4BYTE: return 4'b1111;
         CMD_WSIZE_2BYTE: return lo[1] ? 4'b1100 : 4'b0011;
         default:         return 4'b0001 << lo;
      endcase
   endfunction

endpackage

// File: rtl/cmd_wb.sv
// Command-driven Wishbone master: turns a request (address, word size,
// count, auto-increment) into single-word pipelined Wishbone cycles, taking
// write data from an rx byte stream and returning read data on a tx stream.
module cmd_wb
   import cmd_wb_pkg::*;
#(
   parameter int WB_ADDR_WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   output logic                     o_wb_we,
   output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
   output logic [31:0]              o_wb_data,
   output logic [3:0]               o_wb_sel,
   input  logic [31:0]              i_wb_data,
   input  logic                     i_mreq_valid,
   output logic                     o_mreq_ready,
   input  logic                     i_mreq_wr,
   input  logic [1:0]               i_mreq_wsize,
   input  logic                     i_mreq_aincr,
   input  logic [7:0]               i_mreq_size,
   input  logic [31:0]              i_mreq_addr,
   output logic                     o_rx_ready,
   input  logic [7:0]               i_rx_data,
   input  logic                     i_rx_valid,
   input  logic                     i_tx_ready,
   output logic [7:0]               o_tx_data,
   output logic                     o_tx_valid
);

   // Only the byte-address bits that reach o_wb_addr are kept; higher bits
   // fall away, which gives the modulo-2^WB_ADDR_WIDTH wrap for free.
   localparam int AW = WB_ADDR_WIDTH + 2;

   state_t          state, state_nxt, word_next;
   logic            wr_q, aincr_q;
   logic [1:0]      wsize_q, idx_q, lane;
   logic [7:0]      count_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q, rdata_q;
   logic [2:0]      nbytes;
   logic            last_byte, last_word;
   logic            req_fire, rx_fire, tx_fire, ack_fire, word_done;

   logic            unused_addr_hi;
   assign unused_addr_hi = ^i_mreq_addr[31:AW];

   assign nbytes    = wsize_bytes(wsize_q);
   assign lane      = first_lane(wsize_q, addr_q[1:0]) + idx_q;
   assign last_byte = ({1'b0, idx_q} == nbytes - 3'd1);
   assign last_word = (count_q == 8'd1);

   assign req_fire  = (state == ST_IDLE)   && i_mreq_valid;
   assign rx_fire   = (state == ST_RX)     && i_rx_valid;
   assign tx_fire   = (state == ST_TX)     && i_tx_ready;
   assign ack_fire  = (state == ST_WB_ACK) && i_wb_ack;
   assign word_done = (ack_fire && wr_q) || (tx_fire && last_byte);

   assign o_wb_we   = o_wb_cyc && wr_q;
   assign o_wb_addr = addr_q[AW-1:2];
   assign o_wb_data = wdata_q;
   assign o_wb_sel  = (state == ST_IDLE) ? 4'b0000 : lane_sel(wsize_q, addr_q[1:0]);
   assign o_tx_data = rdata_q[{lane, 3'b000} +: 8];

   // State register; async reset drops cyc/stb immediately since they decode state.
   always_ff @(posedge i_clk or negedge i_rst) begin
      // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
      if (!i_rst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and handshake/bus strobes.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_nxt    = state;
      word_next    = last_word ? ST_IDLE : (wr_q ? ST_RX : ST_WB_REQ);
      o_mreq_ready = 1'b0;
      o_rx_ready   = 1'b0;
      o_tx_valid   = 1'b0;
      o_wb_cyc     = 1'b0;
      o_wb_stb     = 1'b0;
      case (state)
         ST_IDLE: begin
            o_mreq_ready = 1'b1;
            if (i_mreq_valid && (i_mreq_size != 8'd0))
               state_nxt = i_mreq_wr ? ST_RX : ST_WB_REQ;
         end
         ST_RX: begin
            o_rx_ready = 1'b1;
            if (i_rx_valid && last_byte) state_nxt = ST_WB_REQ;
         end
         ST_WB_REQ: begin
            o_wb_cyc = 1'b1;
            o_wb_stb = 1'b1;
            if (!i_wb_stall) state_nxt = ST_WB_ACK;
         end
         ST_WB_ACK: begin
            o_wb_cyc = 1'b1;
            if (i_wb_ack) state_nxt = wr_q ? word_next : ST_TX;
         end
         ST_TX: begin
            o_tx_valid = 1'b1;
            if (i_tx_ready && last_byte) state_nxt = word_next;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, byte packing/unpacking and word/address stepping.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_q    <= 1'b0;
         aincr_q <= 1'b0;
         wsize_q <= 2'd0;
         count_q <= 8'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         idx_q   <= 2'd0;
      end else if (req_fire) begin
         wr_q    <= i_mreq_wr;
         aincr_q <= i_mreq_aincr;
         wsize_q <= i_mreq_wsize;
         count_q <= i_mreq_size;
         addr_q  <= i_mreq_addr[AW-1:0];
         wdata_q <= 32'd0;
         idx_q   <= 2'd0;
      end else if (word_done) begin
         count_q <= count_q - 8'd1;
         if (aincr_q) addr_q <= addr_q + AW'(nbytes);
         wdata_q <= 32'd0;
         idx_q   <= 2'd0;
      end else if (rx_fire) begin
         wdata_q[{lane, 3'b000} +: 8] <= i_rx_data;
         idx_q <= last_byte ? 2'd0 : idx_q + 2'd1;
      end else if (ack_fire) begin
         rdata_q <= i_wb_data;
         idx_q   <= 2'd0;
      end else if (tx_fire) begin
         idx_q <= idx_q + 2'd1;
      end
   end

endmodule

// File: tb/tb_cmd_wb.sv
// Scoreboard bench for cmd_wb: directed requests push expected Wishbone
// transactions and tx bytes; an in-bench Wishbone memory (wb_mem behaviour
// with stall/ack wait states) and a tx monitor pop and compare.
module tb_cmd_wb;
   import cmd_wb_pkg::*;

   logic        i_clk, i_rst;
   logic        o_wb_cyc, o_wb_stb, i_wb_stall, i_wb_ack, o_wb_we;
   logic [7:0]  o_wb_addr;
   logic [31:0] o_wb_data, i_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_mreq_valid, o_mreq_ready, i_mreq_wr, i_mreq_aincr;
   logic [1:0]  i_mreq_wsize;
   logic [7:0]  i_mreq_size;
   logic [31:0] i_mreq_addr;
   logic        o_rx_ready, i_rx_valid, i_tx_ready, o_tx_valid;
   logic [7:0]  i_rx_data, o_tx_data;

   cmd_wb #(.WB_ADDR_WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
      .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_data(i_wb_data),
      .i_mreq_valid(i_mreq_valid), .o_mreq_ready(o_mreq_ready), .i_mreq_wr(i_mreq_wr),
      .i_mreq_wsize(i_mreq_wsize), .i_mreq_aincr(i_mreq_aincr), .i_mreq_size(i_mreq_size),
      .i_mreq_addr(i_mreq_addr),
      .o_rx_ready(o_rx_ready), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid)
   );

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } wb_txn_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_cnt  = 0;
   int          last_tx_cyc = -1;
   int          stall_cfg = 0;
   int          ack_cfg   = 0;
   int          wb_count  = 0;
   logic [31:0] mem [0:255];
   wb_txn_t     exp_wb[$];
   logic [7:0]  exp_tx[$];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic wb_txn_t txn(input logic we, input logic [7:0] a, input logic [3:0] s,
                                   input logic [31:0] d);
      wb_txn_t t;
      t.we = we; t.addr = a; t.sel = s; t.data = d;
      return t;
   endfunction

   // Wishbone memory slave with configurable stall and ack wait states.
   initial begin
      logic [14:0] snap_ctl;
      logic [31:0] snap_dat, rd;
      wb_txn_t     e;
      bit          have;
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      forever begin
         @(negedge i_clk);
         if (i_rst && o_wb_cyc && o_wb_stb) begin
            snap_ctl = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel};
            snap_dat = o_wb_data;
            for (int s = 0; s < stall_cfg; s++) begin
               i_wb_stall = 1'b1;
               @(negedge i_clk);
               check("wb_stall_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel}, snap_ctl);
               check("wb_stall_data", o_wb_data, snap_dat);
            end
            i_wb_stall = 1'b0;
            wb_count++;
            have = (exp_wb.size() > 0);
            check("wb_expected", have, 1'b1);
            rd = mem[o_wb_addr];
            if (have) begin
               e = exp_wb.pop_front();
               check("wb_we", o_wb_we, e.we);
               check("wb_addr", o_wb_addr, e.addr);
               check("wb_sel", o_wb_sel, e.sel);
               if (e.we) check("wb_wdata", o_wb_data, e.data);
            end
            if (o_wb_we)
               for (int l = 0; l < 4; l++)
                  if (o_wb_sel[l]) mem[o_wb_addr][8*l +: 8] = o_wb_data[8*l +: 8];
            @(negedge i_clk);
            check("wb_ack_phase", {o_wb_cyc, o_wb_stb}, 2'b10);
            for (int a = 0; a < ack_cfg && i_rst; a++) @(negedge i_clk);
            if (i_rst) begin
               i_wb_ack  = 1'b1;
               i_wb_data = rd;
               @(negedge i_clk);
               i_wb_ack  = 1'b0;
               i_wb_data = 32'hDEAD_BEEF;
               if (i_rst) check("wb_cyc_drop", o_wb_cyc, 1'b0);
            end
         end
      end
   end

   // Tx monitor: pops one expected byte per handshake, checks hold while stalled.
   initial begin
      bit         hold = 1'b0;
      logic [7:0] hold_val = 8'd0;
      bit         have;
      forever begin
         @(negedge i_clk);
         if (i_rst && o_tx_valid) begin
            if (hold) check("tx_hold", o_tx_data, hold_val);
            if (i_tx_ready) begin
               have = (exp_tx.size() > 0);
               check("tx_expected", have, 1'b1);
               if (have) check("tx_data", o_tx_data, exp_tx.pop_front());
               last_tx_cyc = cyc_cnt;
               hold = 1'b0;
            end else begin
               hold     = 1'b1;
               hold_val = o_tx_data;
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   // A Wishbone cycle must never overlap a pending stream byte.
   always @(negedge i_clk)
      if (i_rst && o_wb_cyc) check("wb_excl", o_rx_ready | o_tx_valid, 1'b0);

   task automatic issue_req(input logic wr, input logic [1:0] ws, input logic ai,
                            input logic [7:0] sz, input logic [31:0] a);
      bit ok = 1'b0;
      @(posedge i_clk); #2;
      i_mreq_wr = wr; i_mreq_wsize = ws; i_mreq_aincr = ai; i_mreq_size = sz; i_mreq_addr = a;
      i_mreq_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_mreq_ready) begin ok = 1'b1; break; end
      end
      check("mreq_accept", ok, 1'b1);
      @(posedge i_clk); #2;
      i_mreq_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] first, input int n);
      bit ok;
      for (int k = 0; k < n; k++) begin
         i_rx_data  = 8'(first + k);
         i_rx_valid = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_rx_ready) begin ok = 1'b1; break; end
         end
         check("rx_accept", ok, 1'b1);
         @(posedge i_clk); #2;
         if (!ok) break;
      end
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clk);
         if (o_mreq_ready) begin ok = 1'b1; break; end
      end
      #1;
      check({name, "_done"}, ok, 1'b1);
      check({name, "_tx_drained"}, exp_tx.size(), 0);
      check({name, "_wb_drained"}, exp_wb.size(), 0);
      check({name, "_ready_after_last"}, last_tx_cyc != cyc_cnt, 1'b1);
   endtask

   initial begin
      int  wb_before;
      bit  ok;
      i_rst = 1'b0;
      i_mreq_valid = 1'b0; i_mreq_wr = 1'b0; i_mreq_wsize = 2'd0; i_mreq_aincr = 1'b0;
      i_mreq_size = 8'd0; i_mreq_addr = 32'd0;
      i_rx_valid = 1'b0; i_rx_data = 8'd0; i_tx_ready = 1'b1;

      // Reset state
      #12;
      check("rst_cycstb", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
      check("rst_streams", {o_rx_ready, o_tx_valid}, 2'b00);
      check("rst_mreq_ready", o_mreq_ready, 1'b1);
      check("rst_wb_addr", o_wb_addr, 8'd0);
      check("rst_wb_data", o_wb_data, 32'd0);
      check("rst_wb_sel", o_wb_sel, 4'd0);
      check("rst_tx_data", o_tx_data, 8'd0);
      @(posedge i_clk); #2;
      i_rst = 1'b1;

      // Write 2BYTE at 0x0C, two words into one memory word
      exp_wb.push_back(txn(1'b1, 8'd3, 4'b0011, 32'h0000_0100));
      exp_wb.push_back(txn(1'b1, 8'd3, 4'b1100, 32'h0302_0000));
      issue_req(1'b1, CMD_WSIZE_2BYTE, 1'b1, 8'd2, 32'h0C);
      send_rx(8'h00, 4);
      wait_idle("wr2");
      check("mem3", mem[3], 32'h0302_0100);

      // Write 4BYTE at 0x10, two full words
      exp_wb.push_back(txn(1'b1, 8'd4, 4'b1111, 32'h0706_0504));
      exp_wb.push_back(txn(1'b1, 8'd5, 4'b1111, 32'h0B0A_0908));
      issue_req(1'b1, CMD_WSIZE_4BYTE, 1'b1, 8'd2, 32'h10);
      send_rx(8'h04, 8);
      wait_idle("wr4");
      check("mem4", mem[4], 32'h0706_0504);
      check("mem5", mem[5], 32'h0B0A_0908);

      // Size 0 completes with no transfer
      wb_before = wb_count;
      issue_req(1'b1, CMD_WSIZE_1BYTE, 1'b1, 8'd0, 32'h40);
      repeat (3) @(negedge i_clk);
      check("size0_ready", o_mreq_ready, 1'b1);
      check("size0_rx_ready", o_rx_ready, 1'b0);
      check("size0_no_wb", wb_count - wb_before, 0);

      // Read 1BYTE with tx back-pressure
      i_tx_ready = 1'b0;
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b0001, 32'd0));
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b0010, 32'd0));
      exp_tx.push_back(8'h04); exp_tx.push_back(8'h05);
      wb_before = wb_count;
      issue_req(1'b0, CMD_WSIZE_1BYTE, 1'b1, 8'd2, 32'h10);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_tx_valid) begin ok = 1'b1; break; end
      end
      check("rd1_tx_valid_seen", ok, 1'b1);
      repeat (10) @(negedge i_clk);
      check("rd1_held_valid", o_tx_valid, 1'b1);
      check("rd1_held_data", o_tx_data, 8'h04);
      check("rd1_one_wb", wb_count - wb_before, 1);
      @(posedge i_clk); #2;
      i_tx_ready = 1'b1;
      wait_idle("rd1");

      // Read 2BYTE and 4BYTE
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b0011, 32'd0));
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b1100, 32'd0));
      for (int b = 4; b < 8; b++) exp_tx.push_back(8'(b));
      issue_req(1'b0, CMD_WSIZE_2BYTE, 1'b1, 8'd2, 32'h10);
      wait_idle("rd2");
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b1111, 32'd0));
      exp_wb.push_back(txn(1'b0, 8'd5, 4'b1111, 32'd0));
      for (int b = 4; b < 12; b++) exp_tx.push_back(8'(b));
      issue_req(1'b0, CMD_WSIZE_4BYTE, 1'b1, 8'd2, 32'h10);
      wait_idle("rd4");

      // Byte address above the Wishbone window wraps to word 4
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b1111, 32'd0));
      for (int b = 4; b < 8; b++) exp_tx.push_back(8'(b));
      issue_req(1'b0, CMD_WSIZE_4BYTE, 1'b1, 8'd1, 32'h410);
      wait_idle("rd_wrap");

      // Stall and ack wait states, no auto-increment
      stall_cfg = 2; ack_cfg = 2;
      for (int w = 0; w < 3; w++) begin
         exp_wb.push_back(txn(1'b0, 8'd4, 4'b0010, 32'd0));
         exp_tx.push_back(8'h05);
      end
      issue_req(1'b0, CMD_WSIZE_1BYTE, 1'b0, 8'd3, 32'h11);
      wait_idle("rd_noinc");
      exp_wb.push_back(txn(1'b1, 8'd8, 4'b1100, 32'h1110_0000));
      exp_wb.push_back(txn(1'b1, 8'd8, 4'b1100, 32'h1312_0000));
      issue_req(1'b1, CMD_WSIZE_2BYTE, 1'b0, 8'd2, 32'h22);
      send_rx(8'h10, 4);
      wait_idle("wr_noinc");
      check("mem8_noinc", mem[8], 32'h1312_0000);

      // Reset while waiting for ack aborts the request
      stall_cfg = 0; ack_cfg = 30;
      exp_wb.push_back(txn(1'b0, 8'd4, 4'b1111, 32'd0));
      issue_req(1'b0, CMD_WSIZE_4BYTE, 1'b1, 8'd2, 32'h10);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_wb_cyc && !o_wb_stb) begin ok = 1'b1; break; end
      end
      check("abort_in_ack", ok, 1'b1);
      #2 i_rst = 1'b0;
      #1;
      check("abort_cycstb", {o_wb_cyc, o_wb_stb}, 2'b00);
      check("abort_mreq_ready", o_mreq_ready, 1'b1);
      check("abort_tx_valid", o_tx_valid, 1'b0);
      check("abort_wb_addr", o_wb_addr, 8'd0);
      repeat (2) @(posedge i_clk);
      #2 i_rst = 1'b1;
      ack_cfg = 1;
      @(negedge i_clk);
      check("post_rst_ready", o_mreq_ready, 1'b1);
      check("post_rst_wb_idle", o_wb_cyc, 1'b0);

      // New request after reset; reserved wsize acts as a single byte
      exp_wb.push_back(txn(1'b1, 8'd8, 4'b0010, 32'h0000_AA00));
      issue_req(1'b1, 2'd0, 1'b1, 8'd1, 32'h21);
      send_rx(8'hAA, 1);
      wait_idle("wr_rsv");
      check("mem8_rsv", mem[8], 32'h1312_AA00);
      exp_wb.push_back(txn(1'b0, 8'd8, 4'b0010, 32'd0));
      exp_tx.push_back(8'hAA);
      issue_req(1'b0, CMD_WSIZE_1BYTE, 1'b1, 8'd1, 32'h21);
      wait_idle("rd_rsv");

      repeat (3) @(negedge i_clk);
      check("final_wb_queue", exp_wb.size(), 0);
      check("final_tx_queue", exp_tx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cmd_wb.md
CMD_WB -- requirements
Module: cmd_wb

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 8: word-address width of the Wishbone master port.
REQ-002 Shared constants CMD_WSIZE_1BYTE=2'd1, CMD_WSIZE_2BYTE=2'd2, CMD_WSIZE_4BYTE=2'd3; 2'd0 reserved.
REQ-003 The block SHALL use one clock, i_clk, and an asynchronous, active-low reset, i_rst.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  clock
- i_rst  in  1  async active-low reset
- o_wb_cyc, o_wb_stb  out  1  WB pipelined cycle/strobe
- i_wb_stall, i_wb_ack  in  1  WB stall/ack
- o_wb_we  out  1  write enable
- o_wb_addr  out  WB_ADDR_WIDTH  word address
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte lanes
- i_wb_data  in  32  read data
- i_mreq_valid  in  1 / o_mreq_ready  out  1  request handshake
- i_mreq_wr  in  1  1=write, 0=read
- i_mreq_wsize  in  2  word size
- i_mreq_aincr  in  1  address auto-increment
- i_mreq_size  in  8  word count
- i_mreq_addr  in  32  byte address
- o_rx_ready  out  1 / i_rx_data  in  8 / i_rx_valid  in  1  write-data byte stream
- i_tx_ready  in  1 / o_tx_data  out  8 / o_tx_valid  out  1  read-data byte stream

Function
REQ-005 States: IDLE, RX, WB_REQ, WB_ACK, TX; o_mreq_ready SHALL be 1 only in IDLE.
REQ-006 On i_mreq_valid&&o_mreq_ready, the block SHALL latch all request fields; size 0 SHALL complete with no transfers (stay IDLE); otherwise, go to RX if write, WB_REQ if read.
REQ-007 Word bytes N: 1BYTE=1, 2BYTE=2, 4BYTE=4; reserved wsize SHALL be treated as 1BYTE.
REQ-008 o_wb_addr SHALL equal current byte address bits [WB_ADDR_WIDTH+1:2], truncated modulo 2^WB_ADDR_WIDTH.
REQ-009 o_wb_sel: 4BYTE=4'b1111; 2BYTE=addr[1]?4'b1100:4'b0011; 1BYTE=4'b0001<<addr[1:0].
REQ-010 RX: o_rx_ready=1; each byte is accepted on i_rx_valid&&o_rx_ready, one per cycle, little-endian into the selected lanes starting at lowest selected lane; unselected lanes =0; after the Nth byte, go to WB_REQ next cycle.
REQ-011 WB_REQ: o_wb_cyc=o_wb_stb=1, o_wb_we=write flag; hold all WB outputs stable until a cycle with !i_wb_stall, then go to WB_ACK with stb=0, cyc=1.
REQ-012 WB_ACK: on i_wb_ack, cyc SHALL drop next cycle; a read SHALL latch i_wb_data and go to TX; a write SHALL advance to the next word.
REQ-013 TX: o_tx_valid=1, o_tx_data = selected lanes in little-endian order; each byte advances on i_tx_valid&&i_tx_ready; data SHALL be held stable while !i_tx_ready; after the Nth byte, advance to the next word.
REQ-014 Next word: remaining count decrements; if aincr=1, byte address += N, otherwise unchanged; at count 0 return to IDLE, otherwise go to RX (write) or WB_REQ (read).
REQ-015 No WB cycle SHALL start while a stream byte is pending; only one WB transaction SHALL be outstanding.
REQ-016 o_rx_ready SHALL be 0 outside RX; o_tx_valid SHALL be 0 outside TX.

Reset
REQ-017 While i_rst=0: state IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_rx_ready, o_tx_valid =0; o_wb_addr, o_wb_data, o_wb_sel, o_tx_data =0; o_mreq_ready=1.
REQ-018 Reset mid-request SHALL abort immediately (cyc/stb drop asynchronously); the request is lost, and no partial data is retained.

Structure
REQ-019 CMD_WSIZE_* constants SHALL live in the shared command defines include, used by cmd_wb and benches.
REQ-020 No sub-module is required; wb_mem (32-bit WB slave with byte-select writes, configurable stall/ack wait states) SHALL be the bench memory model.

Verification
REQ-021 Write 2BYTE, addr 0x0C, aincr=1, size 2, rx bytes 00..03 -> WB writes word 3 sel 0011 data 0x00000100, then word 3 sel 1100 data 0x03020000; mem[3]=0x03020100.
REQ-022 Write 4BYTE, addr 0x10, aincr=1, size 2, rx bytes 04..0B -> mem[4]=0x07060504, mem[5]=0x0B0A0908; exactly 4 rx bytes are consumed per word.
REQ-023 Read 1BYTE, addr 0x10, aincr=1, size 2, tx_ready=0 for 10 cycles -> tx_valid held with 0x04 stable, with no second WB cycle; after tx_ready=1, tx emits 04, 05.
REQ-024 Read 2BYTE addr 0x10 size 2 -> tx emits 04 05 06 07; read 4BYTE -> tx emits 04..0B.
REQ-025 wb_mem with stall and ack wait states, plus aincr=0 size 3 -> same o_wb_addr for all 3 words, outputs stable during stall; o_mreq_ready returns to 1 only after the last byte.
REQ-026 Assert i_rst during WB_ACK -> cyc/stb drop at once; after release, o_mreq_ready=1, and a new request executes correctly.
